// File: rtl/uart_pkg.sv
// Shared UART framing definitions (receiver and transmitter).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        CLEANUP   = 3'd5,
        WAIT_IDLE = 3'd6
    } uart_state_e;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reset value is parameterised.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_D,
    output logic o_Q
);

    logic meta;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta <= RESET_VAL;
            o_Q  <= RESET_VAL;
        end else begin
            meta <= i_D;
            o_Q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling with framing-error detection.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 437,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Frame_Err,
    output logic       o_Parity_Err
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e    state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift_reg;
    logic           rx_sync;
    logic           par_bad;

    sync_2ff #(
        .RESET_VAL(IDLE_LEVEL)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Rst_n (i_Rst_n),
        .i_D     (i_Rx_Serial),
        .o_Q     (rx_sync)
    );

`ifdef UART_RX_PARITY_EN
    logic par_err_q;
    logic par_strobe;

    assign par_bad      = par_err_q;
    assign o_Parity_Err = par_strobe;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            par_err_q  <= 1'b0;
            par_strobe <= 1'b0;
        end else begin
            par_strobe <= 1'b0;
            if (state == PARITY && clk_cnt == CNT_FULL)
                par_err_q <= ((^shift_reg) ^ rx_sync) != PARITY_ODD;
            if (state == STOP && clk_cnt == CNT_FULL)
                par_strobe <= par_err_q;
        end
    end
`else
    // PARITY_ODD has no meaning without the parity stage; it folds to zero.
    assign par_bad      = PARITY_ODD & 1'b0;
    assign o_Parity_Err = 1'b0;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            o_Rx_DV     <= 1'b0;
            o_Rx_Byte   <= '0;
            o_Rx_Active <= 1'b0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_Rx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (rx_sync != IDLE_LEVEL)
                        state <= START;
                end
                START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (rx_sync != IDLE_LEVEL) begin
                            bit_idx     <= '0;
                            o_Rx_Active <= 1'b1;
                            state       <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_sync;
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (clk_cnt == CNT_FULL) begin
                        clk_cnt <= '0;
                        if (rx_sync == IDLE_LEVEL) begin
                            if (!par_bad) begin
                                o_Rx_DV   <= 1'b1;
                                o_Rx_Byte <= shift_reg;
                            end
                            state <= CLEANUP;
                        end else begin
                            o_Frame_Err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                CLEANUP: begin
                    o_Rx_Active <= 1'b0;
                    state       <= IDLE;
                end
                WAIT_IDLE: begin
                    // A held-low line must return high before another start is accepted.
                    if (rx_sync == IDLE_LEVEL) begin
                        o_Rx_Active <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_Rx_Active <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a strobe scoreboard; CLKS_PER_BIT = 16.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int LAT     = 155 + CPB * PBITS;
    localparam int ACT_CYC = 145 + CPB * PBITS;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       o_Rx_DV;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Active;
    logic       o_Frame_Err;
    logic       o_Parity_Err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc = 0;
    int dv_cyc    = 0;
    int act_cnt   = 0;

    // Scoreboard entry: {parity_err, frame_err, dv, byte}
    logic [10:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .PARITY_ODD  (PODD)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_n      (rst_n),
        .i_Rx_Serial  (rx),
        .o_Rx_DV      (o_Rx_DV),
        .o_Rx_Byte    (o_Rx_Byte),
        .o_Rx_Active  (o_Rx_Active),
        .o_Frame_Err  (o_Frame_Err),
        .o_Parity_Err (o_Parity_Err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [10:0] obs;
        if (o_Rx_Active) act_cnt++;
        if (rst_n && (o_Rx_DV || o_Frame_Err || o_Parity_Err)) begin
            obs = {o_Parity_Err, o_Frame_Err, o_Rx_DV, o_Rx_Byte};
            if (o_Rx_DV) dv_cyc = cyc;
            if (exp_q.size() == 0)
                chk("unexpected_strobe", 32'(obs), 32'd0);
            else
                chk("strobe", 32'(obs), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ PODD ^ bad_par);
`else
        if (bad_par) drive_bit(1'b1);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_byte", 32'(o_Rx_Byte), 32'h00);
        chk("rst_dv", 32'(o_Rx_DV), 32'd0);
        chk("rst_active", 32'(o_Rx_Active), 32'd0);
        chk("rst_frame_err", 32'(o_Frame_Err), 32'd0);
        chk("rst_parity_err", 32'(o_Parity_Err), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Single ideal frame
        act_cnt = 0;
        exp_q.push_back({3'b001, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(20);
        drain("a5_drain");
        chk("a5_latency", 32'(dv_cyc - start_cyc), 32'(LAT));
        chk("a5_active_cycles", 32'(act_cnt), 32'(ACT_CYC));
        chk("a5_byte", 32'(o_Rx_Byte), 32'hA5);

        // Short low glitch
        act_cnt = 0;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        idle(40);
        chk("glitch_active", 32'(act_cnt), 32'd0);
        chk("glitch_dv", 32'(o_Rx_DV), 32'd0);
        chk("glitch_state", 32'(dut.state), 32'(IDLE));

        // Framing error followed by held-low line
        exp_q.push_back({3'b010, 8'hA5});
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        drain("fe_drain");
        chk("fe_active_held", 32'(o_Rx_Active), 32'd1);
        chk("fe_byte_kept", 32'(o_Rx_Byte), 32'hA5);
        idle(6);
        chk("fe_active_released", 32'(o_Rx_Active), 32'd0);
        idle(30);

        // Back-to-back frames, zero gap
        exp_q.push_back({3'b001, 8'h00});
        exp_q.push_back({3'b001, 8'hFF});
        exp_q.push_back({3'b001, 8'h81});
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(20);
        drain("b2b_drain");
        chk("b2b_last_byte", 32'(o_Rx_Byte), 32'h81);

        // Reset in the middle of 0x55's data bits
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_byte", 32'(o_Rx_Byte), 32'h00);
        chk("midrst_active", 32'(o_Rx_Active), 32'd0);
        rst_n = 1'b1;
        idle(40);
        chk("postrst_idle_byte", 32'(o_Rx_Byte), 32'h00);
        exp_q.push_back({3'b001, 8'h12});
        send_frame(8'h12, 1'b1, 1'b0);
        idle(20);
        drain("postrst_drain");
        chk("postrst_byte", 32'(o_Rx_Byte), 32'h12);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back({3'b001, 8'h07});
        send_frame(8'h07, 1'b1, 1'b0);
        idle(20);
        drain("par_good_drain");
        exp_q.push_back({3'b100, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1);
        idle(20);
        drain("par_bad_drain");
        chk("par_bad_byte_kept", 32'(o_Rx_Byte), 32'h07);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
